// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: decimates a VSYNC/HREF framed stream to a 32x32 window
// of 4-bit green samples and drives the frame-buffer BRAM write port directly.
module ov7670_capture #(
  parameter int unsigned H_STEP = 20,
  parameter int unsigned V_STEP = 15,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned OUT_H  = 32
) (
  input  logic       wclk,
  input  logic       rst,
  input  logic       capture_en,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] cam_d,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       busy
);

  localparam int unsigned HW = (H_STEP > 1) ? $clog2(H_STEP) : 1;
  localparam int unsigned VW = (V_STEP > 1) ? $clog2(V_STEP) : 1;
  localparam int unsigned XW = $clog2(OUT_W) + 1;
  localparam int unsigned YW = $clog2(OUT_H) + 1;

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  state_t        state;
  logic          vsync_q;
  logic          href_q;
  logic          phase;
  logic          done_pend;
  logic [2:0]    g_hi;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [XW-1:0] xi;
  logic [YW-1:0] yi;

  logic vs_rise;
  logic vs_fall;
  logic line_kept;
  logic pix_kept;
  logic last_pix;
  logic unused_bits;

  assign vs_rise     = vsync & ~vsync_q;
  assign vs_fall     = ~vsync & vsync_q;
  assign line_kept   = (vcnt == '0) && (yi < YW'(OUT_H));
  assign pix_kept    = line_kept && (hcnt == '0) && (xi < XW'(OUT_W));
  assign last_pix    = (yi == YW'(OUT_H - 1)) && (xi == XW'(OUT_W - 1));
  assign unused_bits = ^cam_d[6:3];

  // vsync_q resets high so a vsync already high at release is not taken as a rise.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vsync_q     <= 1'b1;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      done_pend   <= 1'b0;
      g_hi        <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      xi          <= '0;
      yi          <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      href_q      <= href;
      wr_en       <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      case (state)
        IDLE: begin
          if (vs_rise && capture_en) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end

        ARM: begin
          if (vs_fall) begin
            state     <= ACTIVE;
            phase     <= 1'b0;
            done_pend <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
            xi        <= '0;
            yi        <= '0;
          end
        end

        ACTIVE: begin
          if (done_pend) begin
            done_pend  <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (vs_rise) begin
            frame_abort <= 1'b1;
            if (capture_en) begin
              state <= ARM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (href) begin
            phase <= ~phase;
            if (!phase) begin
              g_hi <= cam_d[2:0];
            end else begin
              // Second byte completes the pixel; G[5:2] = {byte1[2:0], byte2[7]}.
              if (pix_kept) begin
                wr_en   <= 1'b1;
                wr_addr <= {yi[YW-2:0], xi[XW-2:0]};
                wr_data <= {g_hi, cam_d[7]};
                xi      <= xi + XW'(1);
                if (last_pix) done_pend <= 1'b1;
              end
              hcnt <= (hcnt == HW'(H_STEP - 1)) ? '0 : hcnt + HW'(1);
            end
          end else begin
            phase <= 1'b0;
            if (href_q) begin
              if (line_kept) yi <= yi + YW'(1);
              vcnt <= (vcnt == VW'(V_STEP - 1)) ? '0 : vcnt + VW'(1);
              hcnt <= '0;
              xi   <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture with a frame-level reference model
// (pixel/line indices mapped to expected BRAM writes). Uses reduced decimation.
module tb_ov7670_capture;

  localparam int H_STEP      = 3;
  localparam int V_STEP      = 2;
  localparam int OUT_W       = 32;
  localparam int OUT_H       = 32;
  localparam int FULL_PX     = OUT_W * H_STEP;
  localparam int FULL_LINES  = OUT_H * V_STEP;
  localparam int ABORT_LINES = 13 * V_STEP + 1;

  logic       wclk = 1'b0;
  logic       rst;
  logic       capture_en;
  logic       vsync;
  logic       href;
  logic [7:0] cam_d;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [3:0] wr_data;
  logic       frame_done;
  logic       frame_abort;
  logic       busy;

  ov7670_capture #(
    .H_STEP(H_STEP), .V_STEP(V_STEP), .OUT_W(OUT_W), .OUT_H(OUT_H)
  ) dut (
    .wclk(wclk), .rst(rst), .capture_en(capture_en), .vsync(vsync),
    .href(href), .cam_d(cam_d), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_abort(frame_abort),
    .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int c;
    int a;
    int d;
  } wr_t;

  int  cyc = 0;
  wr_t exp_q[$];
  wr_t got_q[$];
  int  exp_done[$];
  int  got_done[$];
  int  exp_abort;
  int  got_abort;
  int  checks = 0;
  int  passed = 0;
  bit  m_active;
  bit  m_complete;
  wr_t mw;
  wr_t ew;

  always @(posedge wclk) cyc <= cyc + 1;

  always @(negedge wclk) begin
    if (wr_en === 1'b1) begin
      mw.c = cyc;
      mw.a = int'(wr_addr);
      mw.d = int'(wr_data);
      got_q.push_back(mw);
    end
    if (frame_done === 1'b1) got_done.push_back(cyc);
    if (frame_abort === 1'b1) got_abort++;
  end

  task automatic clear_score();
    exp_q.delete();
    got_q.delete();
    exp_done.delete();
    got_done.delete();
    exp_abort = 0;
    got_abort = 0;
  endtask

  function automatic int count_mismatch();
    int m;
    m = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                      : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].c != exp_q[i].c || got_q[i].a != exp_q[i].a || got_q[i].d != exp_q[i].d)
        m++;
    return m;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge wclk);
      href  = 1'b0;
      cam_d = 8'($urandom);
    end
  endtask

  // A vsync rise ends any frame in flight and arms the next one per capture_en.
  task automatic vsync_pulse(input bit cap);
    @(negedge wclk);
    vsync = 1'b1;
    href  = 1'b0;
    capture_en = cap;
    if (m_active && !m_complete) exp_abort++;
    m_active   = cap;
    m_complete = 1'b0;
    @(negedge wclk);
    capture_en = 1'($urandom);
    repeat (2) @(negedge wclk);
    vsync = 1'b0;
    capture_en = 1'($urandom);
    idle_cycles(3);
  endtask

  task automatic drive_pixel(input int l, input int p, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge wclk);
    href  = 1'b1;
    cam_d = b1;
    @(negedge wclk);
    cam_d = b2;
    if (m_active && !m_complete && (l % V_STEP == 0) && (l / V_STEP < OUT_H) &&
        (p % H_STEP == 0) && (p / H_STEP < OUT_W)) begin
      ew.c = cyc + 1;
      ew.a = (l / V_STEP) * OUT_W + p / H_STEP;
      ew.d = int'({b1[2:0], b2[7]});
      exp_q.push_back(ew);
      if (ew.a == OUT_W * OUT_H - 1) begin
        m_complete = 1'b1;
        exp_done.push_back(cyc + 2);
      end
    end
  endtask

  // mode 0: random bytes, 1: constant 07/E0, 2: column pattern in byte2[7:5]
  task automatic stream_frame(input int lines, input int px, input bit odd, input int mode);
    logic [7:0] b1;
    logic [7:0] b2;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        case (mode)
          1:       begin b1 = 8'h07; b2 = 8'hE0; end
          2:       begin b1 = 8'h00; b2 = {3'(p), 5'b0}; end
          default: begin b1 = 8'($urandom); b2 = 8'($urandom); end
        endcase
        drive_pixel(l, p, b1, b2);
      end
      if (odd) begin
        @(negedge wclk);
        cam_d = 8'($urandom);
      end
      idle_cycles(int'($urandom_range(2, 5)));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_en = 1'b0; vsync = 1'b0; href = 1'b0; cam_d = 8'h00;
    m_active = 1'b0; m_complete = 1'b0;
    clear_score();
    repeat (3) @(negedge wclk);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, frame_abort, busy} !== 18'h0)
      $display("FAIL reset_values: got en=%b addr=%0d data=%0h done=%b abort=%b busy=%b, want all 0",
               wr_en, wr_addr, wr_data, frame_done, frame_abort, busy);
    else passed++;
    rst = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_reset_mid_frame();
    clear_score();
    vsync_pulse(1'b1);
    checks++;
    if (busy !== 1'b1) $display("FAIL rmid_busy_armed: got %b want 1", busy);
    else passed++;
    @(negedge wclk); href = 1'b1; cam_d = 8'h07;
    @(negedge wclk); cam_d = 8'hE0;
    @(posedge wclk); #1;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 4'hF)
      $display("FAIL rmid_first_write: got en=%b addr=%0d data=%0h want 1/0/f", wr_en, wr_addr, wr_data);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, frame_done, busy} !== 3'b000)
      $display("FAIL rmid_async_clear: got en=%b done=%b busy=%b want 0/0/0", wr_en, frame_done, busy);
    else passed++;
    @(negedge wclk); href = 1'b0;
    m_active = 1'b0; m_complete = 1'b0;
    repeat (2) @(negedge wclk);
    rst = 1'b0;
    clear_score();
    stream_frame(2, FULL_PX, 1'b0, 0);
    checks++;
    if (got_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL rmid_no_resume: got writes=%0d busy=%b want 0/0", got_q.size(), busy);
    else passed++;
  endtask

  task automatic check_full(input string nm);
    int mm;
    int gd;
    int ed;
    mm = count_mismatch();
    gd = (got_done.size() > 0) ? got_done[0] : -1;
    ed = (exp_done.size() > 0) ? exp_done[0] : -2;
    checks++;
    if (got_q.size() !== OUT_W * OUT_H)
      $display("FAIL %s_write_count: got %0d want %0d", nm, got_q.size(), OUT_W * OUT_H);
    else passed++;
    checks++;
    if (mm !== 0) $display("FAIL %s_write_seq: got %0d mismatching writes want 0", nm, mm);
    else passed++;
    checks++;
    if (got_done.size() !== 1 || gd !== ed)
      $display("FAIL %s_frame_done: got count=%0d cyc=%0d want count=1 cyc=%0d", nm, got_done.size(), gd, ed);
    else passed++;
    checks++;
    if (got_abort !== 0 || busy !== 1'b0)
      $display("FAIL %s_end_state: got aborts=%0d busy=%b want 0/0", nm, got_abort, busy);
    else passed++;
  endtask

  task automatic test_full_frame();
    int bad;
    clear_score();
    vsync_pulse(1'b1);
    checks++;
    if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy);
    else passed++;
    stream_frame(FULL_LINES, FULL_PX, 1'b0, 1);
    bad = 0;
    foreach (got_q[i]) if (got_q[i].a != i || got_q[i].d != 15) bad++;
    checks++;
    if (bad !== 0) $display("FAIL full_addr_order_data: got %0d bad entries want 0", bad);
    else passed++;
    check_full("full");
  endtask

  task automatic test_column_abort();
    int mm;
    clear_score();
    vsync_pulse(1'b1);
    stream_frame(ABORT_LINES, FULL_PX, 1'b0, 2);
    vsync_pulse(1'b1);
    mm = count_mismatch();
    checks++;
    if (got_q.size() !== 14 * OUT_W)
      $display("FAIL abort_write_count: got %0d want %0d", got_q.size(), 14 * OUT_W);
    else passed++;
    checks++;
    if (mm !== 0) $display("FAIL abort_column_seq: got %0d mismatching writes want 0", mm);
    else passed++;
    checks++;
    if (got_abort !== exp_abort || got_done.size() !== 0)
      $display("FAIL abort_pulse: got aborts=%0d dones=%0d want %0d/0", got_abort, got_done.size(), exp_abort);
    else passed++;
    clear_score();
    stream_frame(FULL_LINES, FULL_PX, 1'b0, 0);
    check_full("after_abort");
  endtask

  task automatic test_capture_off();
    clear_score();
    vsync_pulse(1'b0);
    checks++;
    if (busy !== 1'b0) $display("FAIL off_busy: got %b want 0", busy);
    else passed++;
    stream_frame(FULL_LINES, FULL_PX, 1'b0, 0);
    checks++;
    if (got_q.size() !== 0 || got_done.size() !== 0 || got_abort !== 0 || busy !== 1'b0)
      $display("FAIL off_idle: got writes=%0d dones=%0d aborts=%0d busy=%b want 0/0/0/0",
               got_q.size(), got_done.size(), got_abort, busy);
    else passed++;
  endtask

  task automatic test_surplus();
    clear_score();
    vsync_pulse(1'b1);
    stream_frame(FULL_LINES + 4, FULL_PX + 10, 1'b1, 0);
    check_full("surplus");
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_full_frame();
    test_column_abort();
    test_capture_off();
    test_surplus();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
